// File: rtl/muldiv_pkg.sv
// Shared types and default constants for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DEF_N_BITS   = 32;
  localparam int unsigned DEF_MULT_LAT = 32;
  localparam int unsigned DEF_DIV_LAT  = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MRUN  = 2'd1,
    DRUN  = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_lat_counter.sv
// Loadable down-counter with a zero flag; used to time the unit latency.
module lat_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  // Load has priority; saturate at zero so a stray decrement cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiply/divide unit: captures operands, times the
// unit latency and writes HI/LO. MULDIV_DIVZERO_TRAP_EN enables the divide-by-zero trap.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned N_BITS   = DEF_N_BITS,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [N_BITS-1:0] srcA,
  input  logic [N_BITS-1:0] srcB,
  input  logic              mthi,
  input  logic              mtlo,
  output logic [N_BITS-1:0] unit_a,
  output logic [N_BITS-1:0] unit_b,
  output logic              mult_go,
  output logic              div_go,
  input  logic [N_BITS-1:0] mult_hi,
  input  logic [N_BITS-1:0] mult_lo,
  input  logic [N_BITS-1:0] div_hi,
  input  logic [N_BITS-1:0] div_lo,
  output logic [N_BITS-1:0] hi,
  output logic [N_BITS-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int unsigned CNT_W = $clog2(max_u(MULT_LAT, DIV_LAT));
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_t            r_state, w_state_nxt;
  op_t               r_op, w_op_nxt;
  logic [N_BITS-1:0] r_unit_a, w_unit_a_nxt;
  logic [N_BITS-1:0] r_unit_b, w_unit_b_nxt;
  logic [N_BITS-1:0] r_hi, w_hi_nxt;
  logic [N_BITS-1:0] r_lo, w_lo_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_div_zero, w_div_zero_nxt;
  logic              r_mult_go, w_mult_go_nxt;
  logic              r_div_go, w_div_go_nxt;

  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_load_val;
  logic              w_cnt_dec;
  logic              w_cnt_zero;
  logic              w_div_trap;

`ifdef MULDIV_DIVZERO_TRAP_EN
  assign w_div_trap = start_div && (srcB == '0);
`else
  assign w_div_trap = 1'b0;
`endif

  lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // State and all outputs are registered here; reset returns to IDLE and drops any result in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= OP_MULT;
      r_unit_a   <= '0;
      r_unit_b   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_mult_go  <= 1'b0;
      r_div_go   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_unit_a   <= w_unit_a_nxt;
      r_unit_b   <= w_unit_b_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_div_zero <= w_div_zero_nxt;
      r_mult_go  <= w_mult_go_nxt;
      r_div_go   <= w_div_go_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_unit_a_nxt   = r_unit_a;
    w_unit_b_nxt   = r_unit_b;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_div_zero_nxt = 1'b0;
    w_mult_go_nxt  = 1'b0;
    w_div_go_nxt   = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = MULT_LOAD;
    w_cnt_dec      = 1'b0;

    case (r_state)
      // Divide beats multiply; any start (even a trapped one) beats mthi/mtlo.
      IDLE: begin
        if (start_div) begin
          if (w_div_trap) begin
            w_div_zero_nxt = 1'b1;
          end else begin
            w_state_nxt    = DRUN;
            w_op_nxt       = OP_DIV;
            w_unit_a_nxt   = srcA;
            w_unit_b_nxt   = srcB;
            w_busy_nxt     = 1'b1;
            w_div_go_nxt   = 1'b1;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = DIV_LOAD;
          end
        end else if (start_mult) begin
          w_state_nxt    = MRUN;
          w_op_nxt       = OP_MULT;
          w_unit_a_nxt   = srcA;
          w_unit_b_nxt   = srcB;
          w_busy_nxt     = 1'b1;
          w_mult_go_nxt  = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = MULT_LOAD;
        end else begin
          if (mthi) w_hi_nxt = srcA;
          if (mtlo) w_lo_nxt = srcA;
        end
      end
      MRUN, DRUN: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) w_state_nxt = WRITE;
      end
      WRITE: begin
        if (r_op == OP_DIV) begin
          w_hi_nxt = div_hi;
          w_lo_nxt = div_lo;
        end else begin
          w_hi_nxt = mult_hi;
          w_lo_nxt = mult_lo;
        end
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign unit_a   = r_unit_a;
  assign unit_b   = r_unit_b;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign mult_go  = r_mult_go;
  assign div_go   = r_div_go;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with latency-accurate behavioural mult/div units.
module tb_muldiv_ctrl;

  localparam int unsigned N  = 32;
  localparam int unsigned ML = 32;
  localparam int unsigned DL = 33;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult, start_div, mthi, mtlo;
  logic [N-1:0] srcA, srcB;
  logic [N-1:0] unit_a, unit_b;
  logic         mult_go, div_go;
  logic [N-1:0] mult_hi, mult_lo, div_hi, div_lo;
  logic [N-1:0] hi, lo;
  logic         busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.N_BITS(N), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .srcA(srcA), .srcB(srcB), .mthi(mthi), .mtlo(mtlo),
    .unit_a(unit_a), .unit_b(unit_b), .mult_go(mult_go), .div_go(div_go),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Units: results become valid LAT cycles after the go pulse, garbage before.
  longint       m_prod;
  logic [N-1:0] d_q, d_r;
  int           m_age, d_age;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_age <= 0;
      d_age <= 0;
    end else begin
      if (mult_go) begin
        m_age  <= 1;
        m_prod <= longint'($signed(unit_a)) * longint'($signed(unit_b));
      end else if (m_age != 0 && m_age < 1000) begin
        m_age <= m_age + 1;
      end
      if (div_go) begin
        d_age <= 1;
        if (unit_b != '0) begin
          d_q <= N'($signed(unit_a) / $signed(unit_b));
          d_r <= N'($signed(unit_a) % $signed(unit_b));
        end else begin
          d_q <= '1;
          d_r <= unit_a;
        end
      end else if (d_age != 0 && d_age < 1000) begin
        d_age <= d_age + 1;
      end
    end
  end

  assign mult_hi = (m_age >= int'(ML)) ? m_prod[63:32] : 32'hBAD0_BAD0;
  assign mult_lo = (m_age >= int'(ML)) ? m_prod[31:0]  : 32'h0BAD_0BAD;
  assign div_hi  = (d_age >= int'(DL)) ? d_r : 32'hDEAD_0001;
  assign div_lo  = (d_age >= int'(DL)) ? d_q : 32'hDEAD_0002;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One MULT or DIV from request to the HI/LO write; optional mid-run stray requests.
  task automatic run_op(input bit is_div, input bit also_mult, input bit mt_with_start,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input int inject_at, input string tag);
    logic [N-1:0] eh, el, hi0;
    longint       p;
    int           n;
    bit           early;
    if (is_div) begin
      el = N'($signed(a) / $signed(b));
      eh = N'($signed(a) % $signed(b));
    end else begin
      p  = longint'($signed(a)) * longint'($signed(b));
      eh = p[63:32];
      el = p[31:0];
    end
    hi0        = hi;
    start_div  = is_div;
    start_mult = !is_div || also_mult;
    mthi       = mt_with_start;
    srcA       = a;
    srcB       = b;
    @(posedge clk); #1;
    start_div = 1'b0; start_mult = 1'b0; mthi = 1'b0;
    srcA = $urandom; srcB = $urandom;
    chk({tag, "_busy_up"}, 64'(busy), 64'(1));
    chk({tag, "_mult_go"}, 64'(mult_go), 64'(!is_div));
    chk({tag, "_div_go"}, 64'(div_go), 64'(is_div));
    chk({tag, "_unit_a"}, 64'(unit_a), 64'(a));
    chk({tag, "_unit_b"}, 64'(unit_b), 64'(b));
    chk({tag, "_done_lo"}, 64'(done), 64'(0));
    chk({tag, "_dz_lo"}, 64'(div_zero), 64'(0));
    if (mt_with_start) chk({tag, "_mthi_lost"}, 64'(hi), 64'(hi0));
    n = 1;
    early = 1'b0;
    while (busy && n < 100) begin
      if (n == inject_at) begin
        start_mult = 1'b1; mthi = 1'b1; mtlo = 1'b1; srcA = 32'h55; srcB = 32'h3;
      end
      @(posedge clk); #1;
      start_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (n == 1) chk({tag, "_go_fall"}, 64'(mult_go | div_go), 64'(0));
      if (busy) begin
        n++;
        if (done) early = 1'b1;
      end
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'((is_div ? DL : ML) + 1));
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_early_done"}, 64'(early), 64'(0));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    logic [N-1:0] ra, rb, h0, l0;
    bit           rdiv;
    bit           saw_done;

    reset = 1'b0;
    start_mult = 1'b0; start_div = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_ua", 64'(unit_a), 64'(0));
    chk("rst_ub", 64'(unit_b), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    chk("rst_go", 64'({mult_go, div_go}), 64'(0));

    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFE7, 32'd6, 0, "div_m25_6");
    chk("div_m25_6_lo_const", 64'(lo), 64'(32'hFFFF_FFFC));
    chk("div_m25_6_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
    run_op(1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 0, "div_1_1");
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    run_op(1'b0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");
    chk("mul_7_m3_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
    chk("mul_7_m3_lo_const", 64'(lo), 64'(32'hFFFF_FFEB));
    run_op(1'b1, 1'b0, 1'b0, 32'd1000, 32'd7, 5, "div_inject");
    run_op(1'b1, 1'b1, 1'b0, 32'd100, 32'hFFFF_FFF7, 0, "both_start");
    run_op(1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 0, "mthi_vs_start");

    // Direct HI/LO writes in IDLE.
    @(posedge clk); #1;
    ra = $urandom; rb = $urandom; l0 = lo;
    mthi = 1'b1; srcA = ra;
    @(posedge clk); #1;
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'(ra));
    chk("mthi_lo_kept", 64'(lo), 64'(l0));
    mtlo = 1'b1; srcA = rb;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'(rb));
    chk("mtlo_hi_kept", 64'(hi), 64'(ra));

    for (int i = 0; i < 6; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      ra   = $urandom;
      if (rdiv) begin
        rb = 32'($urandom_range(2, 5000));
        if ($urandom_range(0, 1) == 1) rb = -rb;
      end else begin
        rb = $urandom;
      end
      run_op(rdiv, 1'b0, 1'b0, ra, rb, 0, rdiv ? "rnd_div" : "rnd_mul");
    end

`ifdef MULDIV_DIVZERO_TRAP_EN
    h0 = hi; l0 = lo;
    start_div = 1'b1; srcA = 32'd9; srcB = 32'd0;
    @(posedge clk); #1;
    start_div = 1'b0;
    chk("dz_pulse", 64'(div_zero), 64'(1));
    chk("dz_busy", 64'(busy), 64'(0));
    chk("dz_div_go", 64'(div_go), 64'(0));
    @(posedge clk); #1;
    chk("dz_pulse_end", 64'(div_zero), 64'(0));
    chk("dz_hi_kept", 64'(hi), 64'(h0));
    chk("dz_lo_kept", 64'(lo), 64'(l0));
    chk("dz_still_idle", 64'(busy), 64'(0));
`else
    h0 = hi; l0 = lo;
    chk("no_trap_dz", 64'(div_zero), 64'(0));
`endif

    // Reset 10 cycles into a divide: immediate clear, result never written.
    start_div = 1'b1; srcA = 32'd77; srcB = 32'd5;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    chk("midrst_ua", 64'(unit_a), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst_no_done", 64'(saw_done), 64'(0));
    chk("midrst_hi_after", 64'(hi), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
